// File: rtl/riscv_pkg.sv
// Shared rename-stage sizing: physical register count, reset architectural mapping
// width and the preg index/count types used across the rename stage.
package riscv_pkg;

  localparam int unsigned NUM_PREGS      = 64;
  localparam int unsigned NUM_ARCH       = 32;
  localparam int unsigned NUM_FREE_PORTS = 2;
  localparam int unsigned PREG_W         = $clog2(NUM_PREGS);
  localparam int unsigned PREG_COUNT_W   = PREG_W + 1;

  typedef logic [PREG_W-1:0]       preg_idx_t;
  typedef logic [PREG_COUNT_W-1:0] preg_count_t;

endpackage

// File: rtl/phys_reg_freelist_if.sv
// Rename/commit-side bundle of the physical register free list: allocation grant,
// commit, release ports, flush and the free count.
interface phys_reg_freelist_if #(
  parameter int unsigned NUM_PREGS      = 64,
  parameter int unsigned NUM_FREE_PORTS = 2
);

  localparam int unsigned IDX_W = $clog2(NUM_PREGS);

  logic                                  alloc_req;
  logic                                  alloc_valid;
  logic [IDX_W-1:0]                      alloc_preg;
  logic                                  commit_valid;
  logic [IDX_W-1:0]                      commit_preg;
  logic [NUM_FREE_PORTS-1:0]             free_valid;
  logic [NUM_FREE_PORTS-1:0][IDX_W-1:0]  free_preg;
  logic                                  flush;
  logic [IDX_W:0]                        free_count;

  modport master (
    output alloc_req, commit_valid, commit_preg, free_valid, free_preg, flush,
    input  alloc_valid, alloc_preg, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, commit_preg, free_valid, free_preg, flush,
    output alloc_valid, alloc_preg, free_count
  );

endinterface

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index of the lowest set bit and, when TWO_SIDE
// is set, of the highest set bit. Both indices read zero when no bit is set.
module priority_encoder #(
  parameter int unsigned WIDTH    = 64,
  parameter bit          TWO_SIDE = 1'b0
) (
  input  logic [WIDTH-1:0]         req,
  output logic [$clog2(WIDTH)-1:0] out_LSB,
  output logic [$clog2(WIDTH)-1:0] out_MSB,
  output logic                     valid
);

  localparam int unsigned OUT_W = $clog2(WIDTH);

  always_comb begin
    out_LSB = '0;
    out_MSB = '0;
    valid   = |req;
    // Scan from opposite ends so the last hit wins: lowest for LSB, highest for MSB.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[WIDTH-1-i]) begin
        out_LSB = OUT_W'(WIDTH-1-i);
      end
      if (TWO_SIDE && req[i]) begin
        out_MSB = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/phys_reg_freelist.sv
// Physical register free list: speculative and committed free bitmaps, lowest-index
// grant each cycle, release/commit at retirement and rollback to the committed map on flush.
module phys_reg_freelist
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_PREGS      = riscv_pkg::NUM_PREGS,
  parameter int unsigned NUM_ARCH       = riscv_pkg::NUM_ARCH,
  parameter int unsigned NUM_FREE_PORTS = riscv_pkg::NUM_FREE_PORTS
) (
  input  logic                 clk,
  input  logic                 rst,
  phys_reg_freelist_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [NUM_PREGS-1:0] RESET_MAP   = {NUM_PREGS{1'b1}} << NUM_ARCH;
  localparam logic [CNT_W-1:0]     RESET_COUNT = CNT_W'(NUM_PREGS - NUM_ARCH);

  logic [NUM_PREGS-1:0] spec_free;
  logic [NUM_PREGS-1:0] arch_free;
  logic [NUM_PREGS-1:0] spec_free_nxt;
  logic [NUM_PREGS-1:0] arch_free_nxt;
  logic [CNT_W-1:0]     free_count_q;
  logic [CNT_W-1:0]     free_count_nxt;
  logic [CNT_W-1:0]     release_cnt;
  logic [IDX_W-1:0]     grant_lsb;
  logic [IDX_W-1:0]     grant_msb;
  logic                 grant_valid;
  logic                 alloc_fire;

  priority_encoder #(
    .WIDTH    (NUM_PREGS),
    .TWO_SIDE (1'b1)
  ) u_grant_enc (
    .req     (spec_free),
    .out_LSB (grant_lsb),
    .out_MSB (grant_msb),
    .valid   (grant_valid)
  );

  // Grant depends only on registered state so rename sees no input-to-output path.
  assign bus.alloc_valid = grant_valid;
  assign bus.alloc_preg  = grant_lsb;
  assign bus.free_count  = free_count_q;

  always_comb begin
    alloc_fire     = bus.alloc_req && grant_valid && !bus.flush;
    spec_free_nxt  = spec_free;
    arch_free_nxt  = arch_free;
    release_cnt    = '0;
    free_count_nxt = free_count_q;

    for (int unsigned k = 0; k < NUM_FREE_PORTS; k++) begin
      if (bus.free_valid[k]) begin
        spec_free_nxt[bus.free_preg[k]] = 1'b1;
        arch_free_nxt[bus.free_preg[k]] = 1'b1;
        release_cnt                     = release_cnt + CNT_W'(1);
      end
    end

    if (bus.commit_valid) begin
      arch_free_nxt[bus.commit_preg] = 1'b0;
    end

    if (alloc_fire) begin
      spec_free_nxt[grant_lsb] = 1'b0;
    end

    // Flush picks up this cycle's commit and release updates to the committed map.
    if (bus.flush) begin
      spec_free_nxt  = arch_free_nxt;
      free_count_nxt = CNT_W'($countones(arch_free_nxt));
    end else begin
      free_count_nxt = free_count_q + release_cnt - CNT_W'(alloc_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_free    <= RESET_MAP;
      arch_free    <= RESET_MAP;
      free_count_q <= RESET_COUNT;
    end else begin
      spec_free    <= spec_free_nxt;
      arch_free    <= arch_free_nxt;
      free_count_q <= free_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(free_count_q) == $countones(spec_free))
        else $error("free_count %0d disagrees with spec_free popcount %0d",
                    free_count_q, $countones(spec_free));
      assert ((spec_free & ~arch_free) == '0)
        else $error("spec_free holds a preg that is live in arch_free");
      assert (!grant_valid || (grant_msb >= grant_lsb))
        else $error("grant encoder LSB %0d above MSB %0d", grant_lsb, grant_msb);
      assert (!bus.commit_valid || arch_free[bus.commit_preg])
        else $error("commit of preg %0d already live", bus.commit_preg);
      for (int unsigned k = 0; k < NUM_FREE_PORTS; k++) begin
        assert (!bus.free_valid[k] || !arch_free[bus.free_preg[k]])
          else $error("release of preg %0d already free on port %0d", bus.free_preg[k], k);
        for (int unsigned j = k + 1; j < NUM_FREE_PORTS; j++) begin
          assert (!(bus.free_valid[k] && bus.free_valid[j] && (bus.free_preg[k] == bus.free_preg[j])))
            else $error("ports %0d and %0d release the same preg %0d", k, j, bus.free_preg[k]);
        end
      end
    end
  end

endmodule
